// File: rtl/music_tone_seq_if.sv
// Note-player bus: one note per valid/ready handshake plus the speaker-side
// status outputs. The master side is the song sequencer, the slave side is
// the tone player.
interface music_tone_seq_if #(
    parameter int DIV_WIDTH = 16,
    parameter int DUR_WIDTH = 24
) ();

    logic [DIV_WIDTH-1:0] note_div;    // half-period in clk cycles, 0 = rest
    logic [DUR_WIDTH-1:0] note_dur;    // note length in clk cycles, 0 = drop
    logic                 note_valid;
    logic                 note_ready;
    logic                 mute;
    logic                 speaker;
    logic                 busy;
    logic                 note_done;

    modport master (
        output note_div,
        output note_dur,
        output note_valid,
        output mute,
        input  note_ready,
        input  speaker,
        input  busy,
        input  note_done
    );

    modport slave (
        input  note_div,
        input  note_dur,
        input  note_valid,
        input  mute,
        output note_ready,
        output speaker,
        output busy,
        output note_done
    );

endinterface

// File: rtl/music_tone_seq.sv
// Square-wave note player. Each accepted note runs a half-period divider and
// a duration counter; the speaker output toggles every note_div cycles for
// exactly note_dur cycles, then note_done pulses for one cycle. A note
// offered during the final cycle of the current one is taken at that same
// edge, so back-to-back notes play without an idle gap.
module music_tone_seq #(
    parameter int DIV_WIDTH = 16,
    parameter int DUR_WIDTH = 24
) (
    input  logic            clk,
    input  logic            rst,
    music_tone_seq_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = '0;
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [DUR_WIDTH-1:0] DUR_ZERO = '0;
    localparam logic [DUR_WIDTH-1:0] DUR_ONE  = DUR_WIDTH'(1);

    // registered state
    logic [0:0]           state_q,     state_d;
    logic [DIV_WIDTH-1:0] div_cnt_q,   div_cnt_d;
    logic [DUR_WIDTH-1:0] dur_cnt_q,   dur_cnt_d;
    logic [DIV_WIDTH-1:0] div_reg_q,   div_reg_d;
    logic                 tone_q,      tone_d;
    logic                 speaker_q,   speaker_d;
    logic                 note_done_q, note_done_d;

    // handshake helpers
    logic last_cycle;
    logic note_ready;
    logic accept;
    logic accept_play;
    logic accept_drop;

    // Handshake decode: ready depends on state only, so a sequencer may
    // legally wait for ready before raising valid without a comb loop.
    always_comb begin
        last_cycle  = (state_q == ST_PLAY) && (dur_cnt_q == DUR_ONE);
        note_ready  = (state_q == ST_IDLE) || last_cycle;
        accept      = bus.note_valid && note_ready;
        accept_play = accept && (bus.note_dur != DUR_ZERO);
        accept_drop = accept && (bus.note_dur == DUR_ZERO);
    end

    // Next-state: advance the playing note, then let an accepted note
    // override the counters (covers both IDLE start and gapless reload).
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        dur_cnt_d   = dur_cnt_q;
        div_reg_d   = div_reg_q;
        tone_d      = tone_q;
        note_done_d = 1'b0;

        if (state_q == ST_PLAY) begin
            // Duration runs down to 1; the cycle at 1 is the last one, so
            // the counter never reaches 0 while playing.
            dur_cnt_d = dur_cnt_q - DUR_ONE;

            if (div_reg_q != DIV_ZERO) begin
                // Reload at 0 rather than wrapping: the half-period is
                // exactly div_reg cycles between toggles.
                if (div_cnt_q == DIV_ZERO) begin
                    div_cnt_d = div_reg_q - DIV_ONE;
                    tone_d    = ~tone_q;
                end else begin
                    div_cnt_d = div_cnt_q - DIV_ONE;
                end
            end else begin
                // Rest: silent for the whole duration.
                tone_d = 1'b0;
            end

            if (last_cycle) begin
                // End of note: pulse done and park the tone low so the
                // speaker is silent in IDLE or at the start of the next note.
                note_done_d = 1'b1;
                tone_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        end

        if (accept_play) begin
            // Starting with div_cnt = div-1 places the first toggle exactly
            // div edges after the accept edge.
            state_d   = ST_PLAY;
            div_cnt_d = bus.note_div - DIV_ONE;
            dur_cnt_d = bus.note_dur;
            div_reg_d = bus.note_div;
            tone_d    = 1'b0;
        end else if (accept_drop) begin
            // Zero-length note is consumed and reported as finished at once;
            // the state has already been resolved above.
            note_done_d = 1'b1;
        end

        // Output follows the next tone so the pin changes on the same edge
        // as the tone; mute is sampled at that edge.
        speaker_d = tone_d & ~bus.mute;
    end

    // State registers; reset aborts any note without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            dur_cnt_q   <= '0;
            div_reg_q   <= '0;
            tone_q      <= 1'b0;
            speaker_q   <= 1'b0;
            note_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            dur_cnt_q   <= dur_cnt_d;
            div_reg_q   <= div_reg_d;
            tone_q      <= tone_d;
            speaker_q   <= speaker_d;
            note_done_q <= note_done_d;
        end
    end

    assign bus.note_ready = note_ready;
    assign bus.speaker    = speaker_q;
    assign bus.busy       = (state_q == ST_PLAY);
    assign bus.note_done  = note_done_q;

endmodule

// File: tb/tb_music_tone_seq.sv
// Bench for the note player: a table of single notes with hand-derived
// waveform statistics, directed multi-cycle sequences, random traffic against
// an arithmetic note model, and a max-value run on a narrow instance.
module tb_music_tone_seq;

    localparam int DW = 16;
    localparam int UW = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    music_tone_seq_if #(.DIV_WIDTH(DW), .DUR_WIDTH(UW)) bus ();
    music_tone_seq #(.DIV_WIDTH(DW), .DUR_WIDTH(UW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // narrow instance for full-scale divider/duration values
    music_tone_seq_if #(.DIV_WIDTH(4), .DUR_WIDTH(6)) bus_s ();
    music_tone_seq #(.DIV_WIDTH(4), .DUR_WIDTH(6)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Note model: the playing note is just (start edge, div, dur); outputs
    // follow from the offset m = edge - start.
    bit     m_act = 1'b0;
    longint m_start, m_div, m_dur;
    longint cyc = 0;
    bit     s_spk, s_bsy, s_dn, s_acc;

    task automatic tick(input bit v, input longint d, input longint u, input bit mu);
        bit     last, rdy_exp, acc, done_exp, tone_exp;
        longint m;
        @(negedge clk);
        bus.note_valid = v;
        bus.note_div   = DW'(d);
        bus.note_dur   = UW'(u);
        bus.mute       = mu;
        #1;
        last    = m_act && (cyc - m_start == m_dur);
        rdy_exp = !m_act || last;
        chk("note_ready", bus.note_ready, rdy_exp);
        @(posedge clk);
        acc      = v && rdy_exp;
        done_exp = last || (acc && u == 0);
        if (acc && u != 0) begin
            m_act = 1'b1; m_start = cyc; m_div = d; m_dur = u;
        end else if (last) begin
            m_act = 1'b0;
        end
        tone_exp = 1'b0;
        if (m_act && m_div != 0) begin
            m = cyc - m_start;
            tone_exp = ((m / m_div) % 2) == 1;
        end
        cyc++;
        #1;
        s_spk = bus.speaker; s_bsy = bus.busy; s_dn = bus.note_done; s_acc = acc;
        chk("speaker",   s_spk, tone_exp & ~mu);
        chk("busy",      s_bsy, m_act);
        chk("note_done", s_dn,  done_exp);
    endtask

    typedef struct {
        int div; int dur; int rises; int highs; int busy;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_r, n_h, n_b, n_d, k2, d1, d2, bmin;
        bit prev;

        tbl[0] = '{4, 20, 2, 8, 20};
        tbl[1] = '{1,  7, 3, 3,  7};
        tbl[2] = '{3, 10, 2, 4, 10};
        tbl[3] = '{0, 10, 0, 0, 10};
        tbl[4] = '{5,  5, 0, 0,  5};
        tbl[5] = '{2,  1, 0, 0,  1};
        tbl[6] = '{7, 15, 1, 7, 15};

        rst = 1'b1;
        bus.note_valid = 1'b0; bus.note_div = '0; bus.note_dur = '0; bus.mute = 1'b0;
        bus_s.note_valid = 1'b0; bus_s.note_div = '0; bus_s.note_dur = '0; bus_s.mute = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_speaker", bus.speaker, 1'b0);
        chk("rst_busy",    bus.busy, 1'b0);
        chk("rst_done",    bus.note_done, 1'b0);
        chk("rst_ready",   bus.note_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // table of single notes from IDLE
        for (int i = 0; i < 7; i++) begin
            n_r = 0; n_h = 0; n_b = 0; n_d = 0; prev = 1'b0;
            for (int c = 0; c < tbl[i].dur + 3; c++) begin
                tick(c == 0, tbl[i].div, tbl[i].dur, 1'b0);
                if (s_spk && !prev) n_r++;
                if (s_spk) n_h++;
                if (s_bsy) n_b++;
                if (s_dn)  n_d++;
                prev = s_spk;
            end
            chk($sformatf("tbl%0d_rises", i), n_r, tbl[i].rises);
            chk($sformatf("tbl%0d_highs", i), n_h, tbl[i].highs);
            chk($sformatf("tbl%0d_busy", i),  n_b, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i),  n_d, 1);
        end

        // reset mid-note
        tick(1, 3, 50, 0);
        repeat (9) tick(0, 0, 0, 0);
        chk("pre_rst_speaker", s_spk, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_speaker", bus.speaker, 1'b0);
        chk("midrst_busy",    bus.busy, 1'b0);
        chk("midrst_done",    bus.note_done, 1'b0);
        chk("midrst_ready",   bus.note_ready, 1'b1);
        m_act = 1'b0;
        #3;
        rst = 1'b0;
        n_d = 0;
        repeat (60) begin
            tick(0, 0, 0, 0);
            if (s_dn) n_d++;
        end
        chk("midrst_no_done", n_d, 0);

        // back-to-back, valid held through the handover
        tick(1, 4, 8, 0);
        k2 = -1; d1 = -1; d2 = -1; bmin = 1;
        for (int n = 1; n <= 20; n++) begin
            tick(k2 < 0, 2, 6, 0);
            if (s_acc && k2 < 0) k2 = n;
            if (s_dn && d1 < 0) d1 = n;
            else if (s_dn && d2 < 0) d2 = n;
            if (n < 14 && !s_bsy) bmin = 0;
        end
        chk("b2b_accept_edge", k2, 8);
        chk("b2b_done1", d1, 8);
        chk("b2b_done2", d2, 14);
        chk("b2b_busy_held", bmin, 1);

        // rest note then zero-length note in IDLE
        n_b = 0; n_h = 0; n_d = 0;
        for (int c = 0; c < 12; c++) begin
            tick(c == 0, 0, 10, 0);
            if (s_bsy) n_b++;
            if (s_spk) n_h++;
            if (s_dn)  n_d++;
        end
        chk("rest_busy", n_b, 10);
        chk("rest_speaker", n_h, 0);
        chk("rest_done", n_d, 1);
        tick(1, 5, 0, 0);
        chk("zero_dur_done", s_dn, 1'b1);
        chk("zero_dur_busy", s_bsy, 1'b0);
        tick(0, 0, 0, 0);
        chk("zero_dur_done_clr", s_dn, 1'b0);

        // mute mid-note and a valid pulse while busy
        tick(1, 1, 10, 0);
        for (int n = 1; n <= 12; n++) begin
            tick(n == 4, 3, 5, (n >= 3 && n <= 5));
            if (n == 3) chk("mute_speaker", s_spk, 1'b0);
            if (n == 4) chk("busy_pulse_ignored", s_acc, 1'b0);
            if (n == 7) chk("mute_resume_phase", s_spk, 1'b1);
            if (n == 11) chk("after_note_idle", s_bsy, 1'b0);
        end

        // random traffic against the model
        for (int r = 0; r < 400; r++) begin
            tick(($urandom % 2) == 1,
                 (($urandom % 8) == 0) ? 65535 : $urandom_range(0, 5),
                 $urandom_range(0, 12),
                 ($urandom % 7) == 0);
        end
        tick(0, 0, 0, 0);

        // full-scale values on the narrow instance: div=15, dur=63
        @(negedge clk);
        bus_s.note_valid = 1'b1; bus_s.note_div = 4'hF; bus_s.note_dur = 6'h3F;
        @(posedge clk);
        #1;
        bus_s.note_valid = 1'b0;
        chk("max_busy_start", bus_s.busy, 1'b1);
        chk("max_spk_start", bus_s.speaker, 1'b0);
        for (int m = 1; m <= 65; m++) begin
            @(posedge clk);
            #1;
            chk($sformatf("max_spk_%0d", m), bus_s.speaker, (m < 63) ? ((m / 15) % 2) : 0);
            chk($sformatf("max_busy_%0d", m), bus_s.busy, m < 63);
            chk($sformatf("max_done_%0d", m), bus_s.note_done, m == 63);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
